// File: rtl/lfsr_rng.sv
// lfsr_rng: maximal-length XNOR LFSR (Fibonacci form) random source with a
// valid/ready output stream, rejection sampling against an inclusive limit,
// all-ones seed lockup protection and period/wrap detection.
module lfsr_rng #(
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned OUT_BITS = 4
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_Seed_DV,
  input  logic [NUM_BITS-1:0] i_Seed_Data,
  input  logic [OUT_BITS-1:0] i_Limit,
  output logic [OUT_BITS-1:0] o_Data,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic                o_Seed_Err,
  output logic                o_Wrap,
  output logic [NUM_BITS-1:0] o_Period,
  output logic [NUM_BITS-1:0] o_State
);

  // Tap mask for the XAPP052 polynomial of width n; bit (t-1) set for tap t.
  function automatic logic [31:0] tap_mask(input int unsigned n);
    case (n)
      3:       tap_mask = 32'h0000_0006;
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0060;
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      16:      tap_mask = 32'h0000_D008;
      17:      tap_mask = 32'h0001_2000;
      18:      tap_mask = 32'h0002_0400;
      19:      tap_mask = 32'h0004_0023;
      20:      tap_mask = 32'h0009_0000;
      21:      tap_mask = 32'h0014_0000;
      22:      tap_mask = 32'h0030_0000;
      23:      tap_mask = 32'h0042_0000;
      24:      tap_mask = 32'h00E1_0000;
      25:      tap_mask = 32'h0120_0000;
      26:      tap_mask = 32'h0200_0023;
      27:      tap_mask = 32'h0400_0013;
      28:      tap_mask = 32'h0900_0000;
      29:      tap_mask = 32'h1400_0000;
      30:      tap_mask = 32'h2000_0029;
      31:      tap_mask = 32'h4800_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]          TAP_ALL  = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0]  TAPS     = TAP_ALL[NUM_BITS-1:0];
  localparam logic [NUM_BITS-1:0]  ALL_ONES = '1;

  typedef enum logic {GEN, HOLD} state_t;

  state_t                state_q, state_d;
  logic [NUM_BITS-1:0]   lfsr_q, lfsr_d;
  logic [NUM_BITS-1:0]   seed_q, seed_d;
  logic [NUM_BITS-1:0]   cnt_q, cnt_d;
  logic [NUM_BITS-1:0]   period_q, period_d;
  logic [OUT_BITS-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  seed_err_q, seed_err_d;
  logic                  wrap_q, wrap_d;

  logic                  fb;
  logic [NUM_BITS-1:0]   lfsr_nx;
  logic [OUT_BITS-1:0]   cand;

  assign fb      = ~^(lfsr_q & TAPS);
  assign lfsr_nx = {lfsr_q[NUM_BITS-2:0], fb};
  assign cand    = lfsr_nx[OUT_BITS-1:0];

  // Next-state logic: seed load has priority over stepping and handshakes.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_d     = seed_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    data_d     = data_q;
    valid_d    = valid_q;
    seed_err_d = 1'b0;
    wrap_d     = 1'b0;

    if (i_Seed_DV) begin
      if (i_Seed_Data == ALL_ONES) begin
        lfsr_d     = '0;
        seed_d     = '0;
        seed_err_d = 1'b1;
      end else begin
        lfsr_d = i_Seed_Data;
        seed_d = i_Seed_Data;
      end
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = GEN;
    end else begin
      case (state_q)
        GEN: begin
          if (i_Enable) begin
            lfsr_d = lfsr_nx;
            if (lfsr_nx == seed_q) begin
              wrap_d   = 1'b1;
              period_d = cnt_q + 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
            if (cand <= i_Limit) begin
              data_d  = cand;
              valid_d = 1'b1;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (i_Ready) begin
            valid_d = 1'b0;
            state_d = GEN;
          end
        end
        default: state_d = GEN;
      endcase
    end
  end

  // State register with asynchronous active-low clear.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= GEN;
      lfsr_q     <= '0;
      seed_q     <= '0;
      cnt_q      <= '0;
      period_q   <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      seed_err_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      seed_q     <= seed_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      seed_err_q <= seed_err_d;
      wrap_q     <= wrap_d;
    end
  end

  assign o_Data     = data_q;
  assign o_Valid    = valid_q;
  assign o_Seed_Err = seed_err_q;
  assign o_Wrap     = wrap_q;
  assign o_Period   = period_q;
  assign o_State    = lfsr_q;

endmodule
